clk_period_meter: RTL and testbench
===================================

# clk_period_meter

Measures the period and high time of a slow clock-like signal, such as the divided core clock, in units of the fast input clock. It synchronises the signal into the `clk_in` domain and reports a new measurement on every rising edge. It also flags frequency lock when consecutive periods agree, and flags timeout when the signal stops toggling. It sits beside the clock divider as a monitor/self-check for the slow RISC-V clock and feeds status/debug registers.

## Interface
- `CNT_W`, 16: width of all cycle counts; must satisfy 2^CNT_W > TIMEOUT.
- `TIMEOUT`, 20000: `clk_in` cycles without a rising edge before timeout is declared.
- `LOCK_CNT`, 4: consecutive in-tolerance period comparisons required for lock.
- `TOL`, 1: maximum allowed |period − previous period|, in cycles.

Ports:
- `clk_in`, input, 1: the only clock, fast reference (125 MHz); all logic is on its rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `sig_in`, input, 1: measured signal, asynchronous to `clk_in`.
- `period`, output, CNT_W: last measured rise-to-rise period, in cycles.
- `high_time`, output, CNT_W: last measured rise-to-fall time, in cycles.
- `meas_valid`, output, 1: one-cycle pulse when `period`/`high_time` update.
- `locked`, output, 1: the period is stable within TOL.
- `timeout`, output, 1: no rising edge for TIMEOUT cycles; sticky until the next rise.

## Operation
- **Synchroniser:** two flops `s1` and `s2`, plus a history flop `s3`, all reset to 0.
  - `rise` = s2 & ~s3.
  - `fall` = ~s2 & s3.
- **State machine:** two states, IDLE (reset state) and MEAS.
- **IDLE:**
  - `cnt` holds 0; `fall` is ignored.
  - On `rise`: `cnt` ← 1, `timeout` ← 0, go to MEAS. No `meas_valid` is generated.
- **MEAS, cycle counting:**
  - `cnt` increments by 1 each cycle.
  - On `fall`: `hi_lat` ← `cnt`.
- **MEAS, on `rise`:**
  - `period` ← `cnt`, `high_time` ← `hi_lat`, `meas_valid` ← 1 (next cycle only), `cnt` ← 1.
  - `prev` ← `cnt`.
- **MEAS, timeout:** when `cnt == TIMEOUT` with no `rise` in the same cycle:
  - `timeout` ← 1, `locked` ← 0, `match` ← 0, `have_prev` ← 0, go to IDLE.
  - `period` and `high_time` hold their last values.
- **Lock logic:** evaluated on each rise in MEAS.
  - If `have_prev` and |cnt − prev| ≤ TOL: `match` ← min(`match`+1, LOCK_CNT).
  - Otherwise: `match` ← 0.
  - `have_prev` ← 1.
  - `locked` ← (next `match` == LOCK_CNT); it is registered and updates together with `meas_valid`.
- **Arithmetic:**
  - Unsigned, CNT_W bits.
  - The difference is computed as larger minus smaller, so no wrap occurs.
  - `cnt` never exceeds TIMEOUT, so there is no overflow.
- **Simultaneous events:**
  - `rise` and `cnt == TIMEOUT` in the same cycle: the rise wins and is a normal measurement.
  - `rise` and `fall` cannot coincide.
- **Reset:** asynchronous assertion at any time returns all of the following to 0 and the state to IDLE:
  - All registers and outputs: `period`, `high_time`, `meas_valid`, `locked`, `timeout`.
  - `match`, `have_prev`, `hi_lat`, `cnt`.

## Timing
- **Input latency:** a `sig_in` edge sampled at clock edge k appears as `rise`/`fall` in the cycle after edge k+1.
- **Output latency:** outputs update at edge k+2.
- **Measurement points:**
  - The first `meas_valid` occurs on the second rising edge after reset or timeout.
  - With a constant input, `locked` first asserts on valid number LOCK_CNT+1.
- **Handshake:** `meas_valid` is a single-cycle pulse with no backpressure. `period`/`high_time` are stable until the next pulse.
- **Timeout timing:** `timeout` asserts TIMEOUT cycles after the last processed rise.
- **Input limits:**
  - The minimum measurable period is 2 cycles; high and low phases must each last ≥ 2 cycles to be seen reliably.
  - Faster input is undefined but must not hang the FSM.

## Test plan
1. **Nominal divided clock:** `sig_in` period 10000 cycles, high 5000 → each `meas_valid` shows `period`=10000 and `high_time`=5000. `locked`=1 from the 5th valid onward; `timeout` stays 0.
2. **Jitter and step:** periods alternating 10000 and 10001 → `locked` stays 1. A step to 12000 → `locked`=0 on that valid, then re-asserts 4 valids after the step.
3. **Timeout and recovery:** stop toggling after lock → `timeout`=1 and `locked`=0 exactly 20000 cycles after the last rise, with `period` holding 10000. Resume toggling:
   - First rise clears `timeout` with no valid.
   - Second rise gives `meas_valid` with the correct period.
4. **Short pulses:** period 8, high 2 → `period`=8, `high_time`=2 on every valid.
5. **Reset mid-measurement:** assert `rst` low halfway through a period while locked → all outputs 0 and the FSM in IDLE. After release, the first valid occurs on the second rise and `locked` needs 5 valids again.

Source files
------------

// File: rtl/clk_period_meter.sv
// rtl/clk_period_meter.sv - period/high-time meter for a slow clock-like signal with lock and timeout flags
module clk_period_meter #(
  parameter int CNT_W    = 16,
  parameter int TIMEOUT  = 20000,
  parameter int LOCK_CNT = 4,
  parameter int TOL      = 1
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             locked,
  output logic             timeout
);

  localparam int MW = $clog2(LOCK_CNT + 1);

  typedef enum logic {IDLE, MEAS} state_t;

  state_t           state, state_n;
  logic             s1, s2, s3;
  logic             rise, fall;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] hi_lat, hi_lat_n;
  logic [CNT_W-1:0] prev, prev_n;
  logic [CNT_W-1:0] period_n, high_time_n;
  logic [CNT_W-1:0] diff;
  logic [MW-1:0]    match, match_n;
  logic             have_prev, have_prev_n;
  logic             meas_valid_n, locked_n, timeout_n;

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  // Two-flop synchroniser plus a history flop for edge detection.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // State and measurement registers.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      hi_lat     <= '0;
      prev       <= '0;
      period     <= '0;
      high_time  <= '0;
      match      <= '0;
      have_prev  <= 1'b0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      hi_lat     <= hi_lat_n;
      prev       <= prev_n;
      period     <= period_n;
      high_time  <= high_time_n;
      match      <= match_n;
      have_prev  <= have_prev_n;
      meas_valid <= meas_valid_n;
      locked     <= locked_n;
      timeout    <= timeout_n;
    end
  end

  // Next-state logic: count between rises, latch results on rise, give up after TIMEOUT.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    hi_lat_n     = hi_lat;
    prev_n       = prev;
    period_n     = period;
    high_time_n  = high_time;
    match_n      = match;
    have_prev_n  = have_prev;
    meas_valid_n = 1'b0;
    locked_n     = locked;
    timeout_n    = timeout;
    // Larger minus smaller so the unsigned difference never wraps.
    diff         = (cnt >= prev) ? (cnt - prev) : (prev - cnt);
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (rise) begin
          cnt_n     = CNT_W'(1);
          timeout_n = 1'b0;
          state_n   = MEAS;
        end
      end
      MEAS: begin
        // A rise on the same cycle as the timeout limit is still a valid measurement.
        if (rise) begin
          period_n     = cnt;
          high_time_n  = hi_lat;
          meas_valid_n = 1'b1;
          cnt_n        = CNT_W'(1);
          prev_n       = cnt;
          have_prev_n  = 1'b1;
          if (have_prev && (diff <= CNT_W'(TOL))) begin
            match_n = (match == MW'(LOCK_CNT)) ? match : match + MW'(1);
          end else begin
            match_n = '0;
          end
          locked_n = (match_n == MW'(LOCK_CNT));
        end else if (cnt == CNT_W'(TIMEOUT)) begin
          timeout_n   = 1'b1;
          locked_n    = 1'b0;
          match_n     = '0;
          have_prev_n = 1'b0;
          cnt_n       = '0;
          state_n     = IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
          if (fall) begin
            hi_lat_n = cnt;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_clk_period_meter.sv
// tb/tb_clk_period_meter.sv - self-checking bench for clk_period_meter
module tb_clk_period_meter;

  localparam int CNT_W    = 16;
  localparam int TO       = 200;
  localparam int LOCK_CNT = 4;
  localparam int TOL      = 1;
  localparam int NV       = 24;

  logic             clk_in = 1'b0;
  logic             rst;
  logic             sig_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             locked;
  logic             timeout;

  typedef struct {
    int hi;
    int lo;
    int exp_period;
    int exp_high;
    int exp_locked;
  } vec_t;

  typedef struct {
    int p;
    int h;
    int l;
    int t;
  } mon_t;

  vec_t vecs [NV];
  mon_t mon_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_valid_cyc = 0;

  clk_period_meter #(
    .CNT_W(CNT_W), .TIMEOUT(TO), .LOCK_CNT(LOCK_CNT), .TOL(TOL)
  ) dut (
    .clk_in(clk_in), .rst(rst), .sig_in(sig_in), .period(period),
    .high_time(high_time), .meas_valid(meas_valid), .locked(locked), .timeout(timeout)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Record every measurement pulse.
  always @(negedge clk_in) begin
    if (meas_valid) begin
      mon_q.push_back('{p: int'(period), h: int'(high_time), l: int'(locked), t: int'(timeout)});
      last_valid_cyc = cyc;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic pulse(input int hi, input int lo);
    sig_in = 1'b1;
    repeat (hi) @(negedge clk_in);
    sig_in = 1'b0;
    repeat (lo) @(negedge clk_in);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_period"}, int'(period), 0);
    check({tag, "_high_time"}, int'(high_time), 0);
    check({tag, "_meas_valid"}, int'(meas_valid), 0);
    check({tag, "_locked"}, int'(locked), 0);
    check({tag, "_timeout"}, int'(timeout), 0);
  endtask

  initial begin
    int w;
    // hi, lo, expected period, expected high, expected locked
    vecs[0]  = '{50, 50, 100, 50, 0};
    vecs[1]  = '{50, 50, 100, 50, 0};
    vecs[2]  = '{50, 50, 100, 50, 0};
    vecs[3]  = '{50, 50, 100, 50, 0};
    vecs[4]  = '{50, 50, 100, 50, 1};
    vecs[5]  = '{50, 50, 100, 50, 1};
    vecs[6]  = '{50, 51, 101, 50, 1};
    vecs[7]  = '{50, 50, 100, 50, 1};
    vecs[8]  = '{51, 50, 101, 51, 1};
    vecs[9]  = '{60, 60, 120, 60, 0};
    vecs[10] = '{60, 60, 120, 60, 0};
    vecs[11] = '{60, 60, 120, 60, 0};
    vecs[12] = '{60, 60, 120, 60, 0};
    vecs[13] = '{60, 60, 120, 60, 1};
    vecs[14] = '{2, 6, 8, 2, 0};
    vecs[15] = '{2, 6, 8, 2, 0};
    vecs[16] = '{2, 6, 8, 2, 0};
    vecs[17] = '{2, 6, 8, 2, 0};
    vecs[18] = '{2, 6, 8, 2, 1};
    vecs[19] = '{2, 8, 10, 2, 0};
    vecs[20] = '{3, 6, 9, 3, 0};
    vecs[21] = '{3, 6, 9, 3, 0};
    vecs[22] = '{3, 6, 9, 3, 0};
    vecs[23] = '{3, 6, 9, 3, 1};

    rst    = 1'b0;
    sig_in = 1'b0;
    repeat (3) @(negedge clk_in);
    check_outputs_zero("in_reset");
    rst = 1'b1;
    repeat (3) @(negedge clk_in);
    check_outputs_zero("after_reset");

    // Table-driven measurements, finished by a trailing rise.
    for (int i = 0; i < NV; i++) pulse(vecs[i].hi, vecs[i].lo);
    sig_in = 1'b1;
    repeat (10) @(negedge clk_in);
    check("valid_count", mon_q.size(), NV);
    for (int i = 0; i < NV && i < mon_q.size(); i++) begin
      check($sformatf("v%0d_period", i), mon_q[i].p, vecs[i].exp_period);
      check($sformatf("v%0d_high", i), mon_q[i].h, vecs[i].exp_high);
      check($sformatf("v%0d_locked", i), mon_q[i].l, vecs[i].exp_locked);
      check($sformatf("v%0d_timeout", i), mon_q[i].t, 0);
    end
    check("locked_before_stop", int'(locked), 1);

    // Signal stops: timeout exactly TO cycles after the last processed rise.
    w = 0;
    while (!timeout && w < 3 * TO) begin
      @(negedge clk_in);
      w++;
    end
    check("timeout_asserted", int'(timeout), 1);
    check("timeout_delay", cyc - last_valid_cyc, TO);
    check("timeout_locked", int'(locked), 0);
    check("timeout_period_held", int'(period), 9);
    check("timeout_high_held", int'(high_time), 3);

    // Recovery: first rise clears timeout silently, second rise measures.
    mon_q.delete();
    sig_in = 1'b0;
    repeat (20) @(negedge clk_in);
    sig_in = 1'b1;
    repeat (50) @(negedge clk_in);
    check("recover_timeout_cleared", int'(timeout), 0);
    check("recover_no_valid", mon_q.size(), 0);
    sig_in = 1'b0;
    repeat (50) @(negedge clk_in);
    sig_in = 1'b1;
    repeat (50) @(negedge clk_in);
    check("recover_valid_count", mon_q.size(), 1);
    if (mon_q.size() >= 1) begin
      check("recover_period", mon_q[0].p, 100);
      check("recover_high", mon_q[0].h, 50);
      check("recover_locked", mon_q[0].l, 0);
    end
    // Period exactly equal to the timeout limit: rise wins.
    sig_in = 1'b0;
    repeat (150) @(negedge clk_in);
    sig_in = 1'b1;
    repeat (10) @(negedge clk_in);
    check("edge_to_valid_count", mon_q.size(), 2);
    if (mon_q.size() >= 2) begin
      check("edge_to_period", mon_q[1].p, TO);
      check("edge_to_high", mon_q[1].h, 50);
    end
    check("edge_to_no_timeout", int'(timeout), 0);

    // Lock on short pulses, then reset halfway through a period.
    sig_in = 1'b0;
    repeat (4) @(negedge clk_in);
    for (int i = 0; i < 8; i++) pulse(4, 4);
    check("pre_reset_locked", int'(locked), 1);
    check("pre_reset_period", int'(period), 8);
    sig_in = 1'b1;
    repeat (4) @(negedge clk_in);
    rst = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    sig_in = 1'b0;
    repeat (3) @(negedge clk_in);
    rst = 1'b1;
    mon_q.delete();
    repeat (3) @(negedge clk_in);
    for (int i = 0; i < 6; i++) pulse(4, 4);
    sig_in = 1'b1;
    repeat (10) @(negedge clk_in);
    check("post_reset_valid_count", mon_q.size(), 6);
    for (int i = 0; i < 6 && i < mon_q.size(); i++) begin
      check($sformatf("pr%0d_period", i), mon_q[i].p, 8);
      check($sformatf("pr%0d_high", i), mon_q[i].h, 4);
      check($sformatf("pr%0d_locked", i), mon_q[i].l, (i >= 4) ? 1 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
